// File: rtl/ddr3_req_arbiter.sv
// ddr3_req_arbiter: arbitrates NUM_REQ requesters onto the single DDR3 controller
// CPU port, keeping one transaction outstanding at a time. A winner is accepted
// combinationally in IDLE, issued for one cycle, and tracked through BUSY until
// write ready, read return or a TIMEOUT abort. DONE then returns one response.
// Ports: i_cpu_ck / i_cpu_reset (async, active-high); req_* requester side with
// a one-hot req_ready accept; rsp_* one-hot completion, read data and abort flag;
// m_* controller CPU port.
// Macro DDR3_ARB_ROUND_ROBIN_EN: defined = round-robin search from the requester
// after the last owner; undefined = fixed priority (lowest index wins).
module ddr3_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 29,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 64
) (
    input  logic                      i_cpu_ck,
    input  logic                      i_cpu_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_cmd,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rd_data,
    output logic                      rsp_err,
    output logic                      m_valid,
    output logic                      m_cmd,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wr_data,
    input  logic                      m_data_rdy,
    input  logic                      m_rd_data_valid,
    input  logic [DATA_W-1:0]         m_rd_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   win;
    logic               found;
    logic               grant;
    logic               cmd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               err_q;
    logic [7:0]         cnt;
    logic               done_ok;
    logic               timeout_hit;

`ifdef DDR3_ARB_ROUND_ROBIN_EN
    localparam logic [IDX_W:0] NR = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   sum;

    // Search NUM_REQ slots starting at ptr; sum < 2*NUM_REQ so one subtract wraps.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= NR) begin
                sum = sum - NR;
            end
            if (!found && req_valid[sum[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge i_cpu_ck or posedge i_cpu_reset) begin
        if (i_cpu_reset) begin
            ptr <= '0;
        end else if (state == DONE) begin
            ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
    end
`else
    // Descending scan so the lowest requesting index is the last to write win.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
    end
`endif

    // Gated by reset so req_ready is 0 while reset is held, even with requests up.
    assign grant       = (state == IDLE) && found && m_data_rdy && !i_cpu_reset;
    assign req_ready   = grant ? (NUM_REQ'(1) << win) : '0;

    // Read completion ignores m_data_rdy; write completion ignores read returns.
    assign done_ok     = (state == BUSY) && (cmd_q ? m_data_rdy : m_rd_data_valid);
    assign timeout_hit = (state == BUSY) && !done_ok && (cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (done_ok || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_cpu_ck or posedge i_cpu_reset) begin
        if (i_cpu_reset) begin
            state     <= IDLE;
            owner     <= '0;
            cmd_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner   <= win;
                cmd_q   <= req_cmd[win];
                addr_q  <= req_addr[win*ADDR_W +: ADDR_W];
                wdata_q <= req_wdata[win*DATA_W +: DATA_W];
            end
            // ISSUE always precedes BUSY, so clearing here is clearing on entry.
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 8'd1;
            end
            if (done_ok && !cmd_q) begin
                rd_data_q <= m_rd_data;
            end
            if (state == BUSY) begin
                err_q <= timeout_hit;
            end
        end
    end

    assign m_valid     = (state == ISSUE);
    assign m_cmd       = cmd_q;
    assign m_addr      = addr_q;
    assign m_wr_data   = wdata_q;
    assign rsp_valid   = (state == DONE) ? (NUM_REQ'(1) << owner) : '0;
    assign rsp_err     = (state == DONE) && err_q;
    assign rsp_rd_data = rd_data_q;

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
module tb_ddr3_req_arbiter;
    localparam int NR = 4;
    localparam int AW = 29;
    localparam int DW = 64;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid, req_cmd, req_ready, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rd_data, m_wr_data, m_rd_data;
    logic            rsp_err, m_valid, m_cmd, m_data_rdy, m_rd_data_valid;
    logic [AW-1:0]   m_addr;

    always #5 clk = ~clk;

    ddr3_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_cpu_ck(clk), .i_cpu_reset(rst),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data), .rsp_err(rsp_err),
        .m_valid(m_valid), .m_cmd(m_cmd), .m_addr(m_addr), .m_wr_data(m_wr_data),
        .m_data_rdy(m_data_rdy), .m_rd_data_valid(m_rd_data_valid), .m_rd_data(m_rd_data)
    );

    typedef struct {
        int          owner;
        logic        err;
        logic [DW-1:0] data;
        int          lat;
    } exp_t;

    exp_t          sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] last_rd = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One transaction: drive mask, expect win to be granted, play the controller
    // (drop m_data_rdy while busy, complete after lat BUSY cycles), check response.
    task automatic txn(input logic [NR-1:0] mask, input int win, input logic cmd,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int lat, input logic ret, input logic [DW-1:0] rdata,
                       input logic keep);
        exp_t e;
        int   k;
        bit   seen;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = addr ^ AW'(i ^ win);
            req_wdata[i*DW +: DW] = wdata ^ DW'(i ^ win);
        end
        req_cmd   = {NR{cmd}};
        req_valid = mask;
        e.owner = win;
        e.err   = !cmd && !ret;
        if (!cmd && ret) last_rd = rdata;
        e.data  = last_rd;
        e.lat   = e.err ? TO + 1 : lat + 1;
        sb.push_back(e);

        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1;
        end
        chk("grant_onehot", 64'(req_ready), 64'(4'b1 << win));
        chk("rsp_quiet_idle", 64'(rsp_valid), 64'(0));

        @(posedge clk); #1;
        if (!keep) req_valid[win] = 1'b0;
        m_data_rdy = 1'b0;
        @(negedge clk);
        chk("issue_m_valid", 64'(m_valid), 64'(1));
        chk("issue_m_cmd", 64'(m_cmd), 64'(cmd));
        chk("issue_m_addr", 64'(m_addr), 64'(addr));
        chk("issue_m_wr_data", m_wr_data, wdata);
        chk("issue_no_ready", 64'(req_ready), 64'(0));

        k = 0;
        seen = 0;
        while (!seen && k < 200) begin
            @(posedge clk); #1;
            m_rd_data_valid = 1'b0;
            if (k + 1 == 1 && cmd && lat >= 2) begin
                m_rd_data_valid = 1'b1;   // stray return during a write
                m_rd_data = '1;
            end
            if (k + 1 == lat) begin
                m_data_rdy = 1'b1;
                if (!cmd && ret) begin
                    m_rd_data_valid = 1'b1;
                    m_rd_data = rdata;
                end
            end
            @(negedge clk);
            k++;
            if (k == 1) chk("busy_m_valid_low", 64'(m_valid), 64'(0));
            if (rsp_valid != '0) seen = 1;
        end
        m_rd_data_valid = 1'b0;

        e = sb.pop_front();
        chk("rsp_latency", 64'(k), 64'(e.lat));
        chk("rsp_owner", 64'(rsp_valid), 64'(4'b1 << e.owner));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_rd_data", rsp_rd_data, e.data);
        chk("done_no_ready", 64'(req_ready), 64'(0));
        chk("done_m_addr_held", 64'(m_addr), 64'(addr));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_valid"}, 64'(m_valid), 64'(0));
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
        chk({tag, "_rsp_rd_data"}, rsp_rd_data, 64'(0));
        chk({tag, "_m_cmd"}, 64'(m_cmd), 64'(0));
        chk({tag, "_m_addr"}, 64'(m_addr), 64'(0));
        chk({tag, "_m_wr_data"}, m_wr_data, 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  exp_win;
        bit  seen;
        rst = 1'b1;
        req_valid = '1; req_cmd = '0; req_addr = '0; req_wdata = '0;
        m_data_rdy = 1'b1; m_rd_data_valid = 1'b0; m_rd_data = '0;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b0;

        // All four held valid for 8 transactions, alternating read/write.
        for (int i = 0; i < 8; i++) begin
`ifdef DDR3_ARB_ROUND_ROBIN_EN
            exp_win = i % NR;
`else
            exp_win = 0;
`endif
            txn(4'b1111, exp_win, 1'(i % 2), 29'h100 + AW'(i * 16), 64'h5000 + DW'(i),
                (i % 2) ? 2 : 1, 1'b1, 64'hC0DE_0000 + DW'(i), 1'b1);
        end

        // Single write from requester 2.
        txn(4'b0100, 2, 1'b1, 29'h0001_0008, 64'hA5A5_0000_1234_5678, 4, 1'b1, '0, 1'b0);
        // Single read from requester 1.
        txn(4'b0010, 1, 1'b0, 29'h0000_4440, 64'h0, 3, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);

        // Requester 0 withdraws while the controller is not ready; 3 must win.
        @(posedge clk); #1;
        m_data_rdy = 1'b0;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("no_grant_when_ctrl_busy", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        req_valid = 4'b0000;
        m_data_rdy = 1'b1;
        txn(4'b1000, 3, 1'b1, 29'h0ABC_DEF0, 64'h1111_2222_3333_4444, 1, 1'b1, '0, 1'b0);

        // Read that never returns: timeout abort, then a normal read.
        txn(4'b0001, 0, 1'b0, 29'h0000_0040, 64'h0, 3, 1'b0, '0, 1'b0);
        txn(4'b1000, 3, 1'b0, 29'h0000_0080, 64'h0, 2, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);

        // Reset in the middle of a BUSY read from requester 2.
        @(posedge clk); #1;
        req_cmd = '0;
        req_valid = 4'b0100;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1;
        end
        chk("pre_reset_grant", 64'(req_ready), 64'(4'b0100));
        @(posedge clk); #1;
        req_valid = '0;
        m_data_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        req_valid = 4'b1111;
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        m_rd_data_valid = 1'b1;
        m_rd_data = 64'hFFFF_0000_FFFF_0000;
        m_data_rdy = 1'b1;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            chk("reset_no_rsp", 64'(rsp_valid), 64'(0));
        end
        @(posedge clk); #1;
        m_rd_data_valid = 1'b0;
        req_valid = '0;
        rst = 1'b0;
        last_rd = '0;
        txn(4'b1111, 0, 1'b1, 29'h0000_0100, 64'h7777_8888_9999_AAAA, 2, 1'b1, '0, 1'b0);

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
